// File: rtl/wb_bus_arbiter.sv
// Round-robin arbiter for the five-source writeback bus, with a one-cycle turnaround between owners.
// Define ARB_HOLD_LIMIT_EN to force release after MAX_HOLD grant cycles when another source waits.
module wb_bus_arbiter #(
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic [4:0] req_i,
    output logic [4:0] gnt_o,
    output logic [2:0] sel_o,
    output logic       bus_valid_o,
    output logic       owner_hold_o
);

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        TURN
    } state_e;

    state_e     state_q, state_d;
    logic [4:0] gnt_q, gnt_d;
    logic [2:0] sel_q, sel_d;
    logic [2:0] last_q, last_d;
    logic       busValid_q;
    logic [2:0] winner;
    logic [2:0] idx;
    logic       found;
    logic       forceRel;
    logic       holdPulse_d;

    if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : gen_bad_max_hold
        $error("wb_bus_arbiter: MAX_HOLD must be in 1..255");
    end

    // Search starts just past the last owner, so the previous winner is always considered last.
    always_comb begin
        winner = last_q;
        found  = 1'b0;
        idx    = 3'd0;
        for (int k = 1; k <= 5; k++) begin
            idx = 3'((int'(last_q) + k) % 5);
            if (!found && req_i[idx]) begin
                winner = idx;
                found  = 1'b1;
            end
        end
    end

`ifdef ARB_HOLD_LIMIT_EN
    logic [7:0] holdCnt_q, holdCnt_d;
    logic       holdPulse_q;

    assign forceRel     = (holdCnt_q == 8'(MAX_HOLD - 1)) && |(req_i & ~gnt_q);
    assign owner_hold_o = holdPulse_q;

    always_comb begin
        holdCnt_d = holdCnt_q;
        if (state_q != GRANT) begin
            holdCnt_d = 8'd0;
        end else if (holdCnt_q != 8'hFF) begin
            holdCnt_d = holdCnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            holdCnt_q   <= 8'd0;
            holdPulse_q <= 1'b0;
        end else begin
            holdCnt_q   <= holdCnt_d;
            holdPulse_q <= holdPulse_d;
        end
    end
`else
    assign forceRel     = 1'b0;
    assign owner_hold_o = 1'b0;
`endif

    // sel keeps the previous owner while the bus is idle so the mux input never changes spuriously.
    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        sel_d       = sel_q;
        last_d      = last_q;
        holdPulse_d = 1'b0;
        case (state_q)
            GRANT: begin
                if (!(|(req_i & gnt_q)) || forceRel) begin
                    state_d     = TURN;
                    gnt_d       = 5'b00000;
                    holdPulse_d = forceRel;
                end
            end
            default: begin
                if (|req_i) begin
                    state_d = GRANT;
                    gnt_d   = 5'b00001 << winner;
                    sel_d   = winner;
                    last_d  = winner;
                end else begin
                    state_d = IDLE;
                    gnt_d   = 5'b00000;
                end
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q    <= IDLE;
            gnt_q      <= 5'b00000;
            sel_q      <= 3'd0;
            last_q     <= 3'd4;
            busValid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            sel_q      <= sel_d;
            last_q     <= last_d;
            busValid_q <= |gnt_d;
        end
    end

    assign gnt_o       = gnt_q;
    assign sel_o       = sel_q;
    assign bus_valid_o = busValid_q;

endmodule

// File: tb/tb_wb_bus_arbiter.sv
// Directed bench for wb_bus_arbiter: reset, rotation, single requester, wrap-around,
// hold limit (both builds of ARB_HOLD_LIMIT_EN) and reset in the middle of a grant.
module tb_wb_bus_arbiter;

    logic       clk = 1'b0;
    logic       rstN = 1'b0;
    logic [4:0] req = 5'b00000;
    logic [4:0] gnt;
    logic [2:0] sel;
    logic       busValid;
    logic       ownerHold;

    int checkCount = 0;
    int passCount  = 0;

    wb_bus_arbiter #(.MAX_HOLD(4)) dut (
        .clk_i       (clk),
        .rst_n_i     (rstN),
        .req_i       (req),
        .gnt_o       (gnt),
        .sel_o       (sel),
        .bus_valid_o (busValid),
        .owner_hold_o(ownerHold)
    );

    always #5 clk = ~clk;

    // Drive inputs, then advance one rising edge and settle 1 time unit past it.
    task automatic applyStimulus(input logic rstVal, input logic [4:0] reqVal);
        rstN = rstVal;
        req  = reqVal;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [4:0] expGnt,
                               input logic [2:0] expSel, input logic expHold);
        checkCount++;
        assert (gnt === expGnt) passCount++;
        else $error("[TB] FAIL %s gnt observed=%b expected=%b", tag, gnt, expGnt);
        checkCount++;
        assert (sel === expSel) passCount++;
        else $error("[TB] FAIL %s sel observed=%0d expected=%0d", tag, sel, expSel);
        checkCount++;
        assert (busValid === (|expGnt)) passCount++;
        else $error("[TB] FAIL %s bus_valid observed=%b expected=%b", tag, busValid, |expGnt);
        checkCount++;
        assert (ownerHold === expHold) passCount++;
        else $error("[TB] FAIL %s owner_hold observed=%b expected=%b", tag, ownerHold, expHold);
    endtask

    initial begin
        // Reset with every source requesting, then release: source 0 wins first.
        applyStimulus(1'b0, 5'b11111);
        applyStimulus(1'b0, 5'b11111);
        checkOutput("reset", 5'b00000, 3'd0, 1'b0);
        applyStimulus(1'b1, 5'b11111);
        checkOutput("first_grant", 5'b00001, 3'd0, 1'b0);

        // Rotation over sources 0, 2, 4, 0 with a single idle cycle between owners.
        applyStimulus(1'b0, 5'b10101);
        checkOutput("rot_reset", 5'b00000, 3'd0, 1'b0);
        applyStimulus(1'b1, 5'b10101);
        checkOutput("rot_g0_a", 5'b00001, 3'd0, 1'b0);
        applyStimulus(1'b1, 5'b10101);
        applyStimulus(1'b1, 5'b10101);
        checkOutput("rot_g0_c", 5'b00001, 3'd0, 1'b0);
        applyStimulus(1'b1, 5'b10100);
        checkOutput("rot_turn0", 5'b00000, 3'd0, 1'b0);
        applyStimulus(1'b1, 5'b10101);
        checkOutput("rot_g2_a", 5'b00100, 3'd2, 1'b0);
        applyStimulus(1'b1, 5'b10101);
        applyStimulus(1'b1, 5'b10101);
        checkOutput("rot_g2_c", 5'b00100, 3'd2, 1'b0);
        applyStimulus(1'b1, 5'b10001);
        checkOutput("rot_turn2", 5'b00000, 3'd2, 1'b0);
        applyStimulus(1'b1, 5'b10101);
        checkOutput("rot_g4_a", 5'b10000, 3'd4, 1'b0);
        applyStimulus(1'b1, 5'b10101);
        applyStimulus(1'b1, 5'b10101);
        checkOutput("rot_g4_c", 5'b10000, 3'd4, 1'b0);
        applyStimulus(1'b1, 5'b00101);
        checkOutput("rot_turn4", 5'b00000, 3'd4, 1'b0);
        applyStimulus(1'b1, 5'b10101);
        checkOutput("rot_g0_again", 5'b00001, 3'd0, 1'b0);
        applyStimulus(1'b1, 5'b00000);
        checkOutput("rot_release", 5'b00000, 3'd0, 1'b0);
        applyStimulus(1'b1, 5'b00000);
        checkOutput("rot_idle", 5'b00000, 3'd0, 1'b0);

        // Single requester keeps the bus; sel stays at 3 after it lets go.
        applyStimulus(1'b1, 5'b01000);
        checkOutput("single_first", 5'b01000, 3'd3, 1'b0);
        for (int i = 0; i < 9; i++) begin
            applyStimulus(1'b1, 5'b01000);
            checkOutput("single_hold", 5'b01000, 3'd3, 1'b0);
        end
        applyStimulus(1'b1, 5'b00000);
        checkOutput("single_drop", 5'b00000, 3'd3, 1'b0);
        applyStimulus(1'b1, 5'b00000);
        checkOutput("single_idle", 5'b00000, 3'd3, 1'b0);

        // Wrap-around: from last=4 source 0 wins; from last=3 source 4 wins.
        applyStimulus(1'b0, 5'b10001);
        checkOutput("wrap_reset", 5'b00000, 3'd0, 1'b0);
        applyStimulus(1'b1, 5'b10001);
        checkOutput("wrap_last4", 5'b00001, 3'd0, 1'b0);
        applyStimulus(1'b1, 5'b00000);
        checkOutput("wrap_turn_a", 5'b00000, 3'd0, 1'b0);
        applyStimulus(1'b1, 5'b01000);
        checkOutput("wrap_take3", 5'b01000, 3'd3, 1'b0);
        applyStimulus(1'b1, 5'b10001);
        checkOutput("wrap_turn_b", 5'b00000, 3'd3, 1'b0);
        applyStimulus(1'b1, 5'b10001);
        checkOutput("wrap_last3", 5'b10000, 3'd4, 1'b0);

        // Hold limit with MAX_HOLD=4: source 1 owns, source 2 joins on the second grant cycle.
        applyStimulus(1'b0, 5'b00010);
        applyStimulus(1'b1, 5'b00010);
        checkOutput("hold_g1", 5'b00010, 3'd1, 1'b0);
        applyStimulus(1'b1, 5'b00010);
        checkOutput("hold_g2", 5'b00010, 3'd1, 1'b0);
        applyStimulus(1'b1, 5'b00110);
        checkOutput("hold_g3", 5'b00010, 3'd1, 1'b0);
        applyStimulus(1'b1, 5'b00110);
        checkOutput("hold_g4", 5'b00010, 3'd1, 1'b0);
`ifdef ARB_HOLD_LIMIT_EN
        applyStimulus(1'b1, 5'b00110);
        checkOutput("hold_force", 5'b00000, 3'd1, 1'b1);
        applyStimulus(1'b1, 5'b00110);
        checkOutput("hold_next", 5'b00100, 3'd2, 1'b0);
`else
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b1, 5'b00110);
            checkOutput("hold_kept", 5'b00010, 3'd1, 1'b0);
        end
`endif

        // Reset in the middle of a grant clears everything at that edge, no TURN cycle.
        applyStimulus(1'b0, 5'b00010);
        applyStimulus(1'b1, 5'b00010);
        checkOutput("mid_grant", 5'b00010, 3'd1, 1'b0);
        applyStimulus(1'b0, 5'b00010);
        checkOutput("mid_reset", 5'b00000, 3'd0, 1'b0);
        applyStimulus(1'b1, 5'b00010);
        checkOutput("mid_regrant", 5'b00010, 3'd1, 1'b0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
